imm_encoder: RTL
================

Name: imm_encoder

Overview:
- Inverse of the immediate sign-extender: packs a 32-bit immediate back into the 25-bit instruction fragment inst[31:7] for types I/S/U/UJ/B.
- Non-immediate fields (rd, rs1, rs2, funct3) are merged in from a base fragment.
- Flags immediates that cannot be represented in the selected format.
- Sits between the test-program builder/loader and instruction memory, behind a valid/ready input and a 2-entry output buffer.

Parameters:
- FRAG_W, 25, fragment width; maps to inst[31:7]. Fixed; asserted equal to 25.
- CNT_W, 16, width of the error counter (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  buffer can accept
- in_op  in  3  000 I, 001 S, 010 U, 011 UJ, 100 B, others RAW
- in_imm  in  32  immediate, already sign-extended
- in_base  in  25  fragment carrying the non-immediate fields
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts
- out_frag  out  25  packed fragment (fragment bit k = inst bit k+7)
- out_err  out  1  immediate not representable
- err_cnt  out  CNT_W  only with IMM_ENC_ERR_CNT_EN

Behaviour:
- Packing (f = out_frag, b = in_base):
  - I: f[24:13]=imm[11:0]; f[12:0]=b[12:0]
  - S: f[24:18]=imm[11:5]; f[4:0]=imm[4:0]; f[17:5]=b[17:5]
  - U: f[24:5]=imm[31:12]; f[4:0]=b[4:0]
  - UJ: f[24]=imm[20]; f[23:14]=imm[10:1]; f[13]=imm[11]; f[12:5]=imm[19:12]; f[4:0]=b[4:0]
  - B: f[24]=imm[12]; f[23:18]=imm[10:5]; f[4:1]=imm[4:1]; f[0]=imm[11]; f[17:5]=b[17:5]
  - RAW: f=imm[24:0]
- Error rules (err=1 if violated):
  - I/S: imm[31:11] all equal.
  - U: imm[11:0]==0.
  - UJ: imm[31:20] all equal and imm[0]==0.
  - B: imm[31:12] all equal and imm[0]==0.
  - RAW: imm[31:25]==0.
- On error the fragment is still packed from the truncated bits; the entry is still delivered.
- Buffer: 2-entry FIFO of {frag, err}; count is 0..2.
  - in_ready = (count<2), combinational from registered count only, never from in_valid.
  - Push on in_valid&&in_ready. Pop on out_valid&&out_ready.
  - out_valid = (count>0). out_frag/out_err come from the head entry and are registered.
- Latency: an entry accepted in cycle N is visible at out_* in cycle N+1 (minimum). Throughput is 1 per cycle while out_ready=1.
- Simultaneous push and pop:
  - count=1: count stays 1; the new entry becomes head next cycle.
  - count=2: push is impossible (in_ready=0); pop only.
- Order is strict FIFO. out_frag/out_err stay stable while out_valid&&!out_ready.
- Reset (async assert, any time, including mid-transfer):
  - count=0, out_valid=0, out_frag=0, out_err=0, err_cnt=0, in_ready=1 in the first cycle after deassert.
  - Buffered entries are discarded.
- in_op/in_imm/in_base are sampled only on push.

Optional Feature:
- IMM_ENC_ERR_CNT_EN defined:
  - err_cnt port is present.
  - Increments by 1 on each push whose err=1; saturates at all-ones.
  - Cleared only by reset.
- Undefined: no err_cnt port and no counter logic; all other behaviour is identical.

Decomposition:
- Package imm_enc_pkg: op codes IMM_OP_I/S/U/UJ/B (3'b000..3'b100), FRAG_W=25, and a struct/typedef for a FIFO entry {frag[24:0], err}.
- One sub-module, imm_pack: purely combinational (op, imm, base) -> (frag, err).
- Top level holds the 2-entry FIFO, pointers, count and optional counter.

Test Plan:
- I, imm=0xFFFFF800 (-2048), base=0x0001FFF, out_ready=1 -> next cycle out_valid=1, out_frag=0x1001FFF, err=0.
- UJ, imm=0x00000801, base=0 -> err=1 (odd), frag=0x0002000; with IMM_ENC_ERR_CNT_EN, err_cnt=1.
- B, imm=0xFFFFFFFE (-2) -> frag=0x1FC001F, err=0; B, imm=0x00001000 -> err=1.
- Backpressure: out_ready=0, push 3 back-to-back -> in_ready falls after 2 accepts; 3rd held until out_ready=1; outputs appear in order, stable while stalled.
- count=1 with push+pop in the same cycle -> count stays 1, no drop, no duplicate; at count=2, in_valid=1 -> no accept.
- Assert rst_n low mid-stream with 2 entries buffered -> out_valid=0 and in_ready=1 immediately; no stale entries after release.

Source files
------------

// File: rtl/imm_enc_pkg.sv
// Shared types for the immediate encoder: op codes, fragment width, FIFO entry.
// Consumed by imm_pack and imm_encoder through a wildcard import.
package imm_enc_pkg;

  localparam int FRAG_W = 25;

  typedef enum logic [2:0] {
    IMM_OP_I  = 3'b000,
    IMM_OP_S  = 3'b001,
    IMM_OP_U  = 3'b010,
    IMM_OP_UJ = 3'b011,
    IMM_OP_B  = 3'b100
  } imm_op_e;

  typedef struct packed {
    logic [FRAG_W-1:0] frag;
    logic              err;
  } imm_entry_t;

  // True when imm[31:msb] are all copies of one bit, i.e. the value fits a signed field ending at msb.
  function automatic logic sign_fits(input logic [31:0] imm, input int msb);
    logic [31:0] hi;
    hi = $signed(imm) >>> msb;
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response bundle between the program loader (master) and imm_encoder (slave).
interface imm_encoder_if;
  import imm_enc_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [31:0]       in_imm;
  logic [FRAG_W-1:0] in_base;
  logic              out_valid;
  logic              out_ready;
  logic [FRAG_W-1:0] out_frag;
  logic              out_err;

  modport master (
    output in_valid, in_op, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_frag, out_err
  );

  modport slave (
    input  in_valid, in_op, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_frag, out_err
  );

endinterface

// File: rtl/imm_pack.sv
// Combinational packer: scatters a sign-extended immediate into inst[31:7]
// for the selected format and flags values the format cannot hold.
module imm_pack
  import imm_enc_pkg::*;
(
  input  logic [2:0]        i_op,
  input  logic [31:0]       i_imm,
  input  logic [FRAG_W-1:0] i_base,
  output logic [FRAG_W-1:0] o_frag,
  output logic              o_err
);

  // Start from the base so register/funct fields pass through untouched.
  always_comb begin
    o_frag = i_base;
    o_err  = 1'b0;
    case (imm_op_e'(i_op))
      IMM_OP_I: begin
        o_frag[24:13] = i_imm[11:0];
        o_err         = !sign_fits(i_imm, 11);
      end
      IMM_OP_S: begin
        o_frag[24:18] = i_imm[11:5];
        o_frag[4:0]   = i_imm[4:0];
        o_err         = !sign_fits(i_imm, 11);
      end
      IMM_OP_U: begin
        o_frag[24:5] = i_imm[31:12];
        o_err        = |i_imm[11:0];
      end
      IMM_OP_UJ: begin
        o_frag[24]    = i_imm[20];
        o_frag[23:14] = i_imm[10:1];
        o_frag[13]    = i_imm[11];
        o_frag[12:5]  = i_imm[19:12];
        o_err         = !sign_fits(i_imm, 20) || i_imm[0];
      end
      IMM_OP_B: begin
        o_frag[24]    = i_imm[12];
        o_frag[23:18] = i_imm[10:5];
        o_frag[4:1]   = i_imm[4:1];
        o_frag[0]     = i_imm[11];
        o_err         = !sign_fits(i_imm, 12) || i_imm[0];
      end
      default: begin
        o_frag = i_imm[24:0];
        o_err  = |i_imm[31:25];
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder top: packer feeding a 2-entry head/tail output buffer.
// Define IMM_ENC_ERR_CNT_EN to add the saturating err_cnt output.
module imm_encoder
  import imm_enc_pkg::*;
#(
  parameter int FRAG_W = 25,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef IMM_ENC_ERR_CNT_EN
  output logic [CNT_W-1:0] err_cnt,
`endif
  imm_encoder_if.slave     bus
);

  if (FRAG_W != imm_enc_pkg::FRAG_W || CNT_W < 1) begin : g_param_check
    $error("imm_encoder: FRAG_W must be 25 and CNT_W at least 1");
  end

  logic [1:0] r_count;
  imm_entry_t r_head;
  imm_entry_t r_tail;
  imm_entry_t w_entry;
  logic       w_push;
  logic       w_pop;

  imm_pack u_pack (
    .i_op   (bus.in_op),
    .i_imm  (bus.in_imm),
    .i_base (bus.in_base),
    .o_frag (w_entry.frag),
    .o_err  (w_entry.err)
  );

  assign bus.in_ready  = (r_count != 2'd2);
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_frag  = r_head.frag;
  assign bus.out_err   = r_head.err;

  assign w_push = bus.in_valid && bus.in_ready;
  assign w_pop  = bus.out_valid && bus.out_ready;

  // Head is the output register; tail only holds the second entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      if (w_pop) begin
        if (r_count == 2'd2) r_head <= r_tail;
        else if (w_push)     r_head <= w_entry;
      end else if (w_push) begin
        if (r_count == 2'd0) r_head <= w_entry;
        else                 r_tail <= w_entry;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

`ifdef IMM_ENC_ERR_CNT_EN
  logic [CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           r_err_cnt <= '0;
    else if (w_push && w_entry.err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule
